// File: rtl/data_mem_pkg.sv
// data_mem_pkg: shared types and byte-lane helper for the data-memory responder.
package data_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} dm_state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_t;
  function automatic logic [7:0] byte_mask(input size_t size, input logic [2:0] lane);
    logic [7:0] m;
    m = 8'((9'd1 << (4'd1 << size)) - 9'd1);
    return m << lane;
  endfunction
endpackage

// File: rtl/dm_ram.sv
// dm_ram: 64-bit word RAM with per-byte write enables, synchronous write and combinational read.
module dm_ram #(
  parameter int DEPTH = 1024,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [AW-1:0] idx,
  input  logic [7:0]    we,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);
  logic [63:0] mem [DEPTH];
  always_ff @(posedge clk)
    for (int b = 0; b < 8; b++)
      if (we[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
  assign rdata = mem[idx];
endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding load/store responder with programmable latency
// over a little-endian 64-bit RAM.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = WAIT_CYCLES > 2 ? $clog2(WAIT_CYCLES) : 1;
  dm_state_t     state;
  logic [CW-1:0] cnt;
  logic          lat_write;
  logic [AW+2:0] lat_addr;
  size_t         lat_size;
  logic [63:0]   lat_wdata;
  logic          a_write, accept, done, mis;
  logic [AW+2:0] a_addr;
  size_t         a_size;
  logic [63:0]   a_wdata, ram_rd, sz_mask, ld_data;
  logic [2:0]    lane;
  logic [7:0]    we;
  logic          unused_ok;
  assign unused_ok = ^req_addr[63:AW+3];
  // With zero wait the access completes on the accept edge, so use live request fields in IDLE.
  assign a_write = state == IDLE ? req_write : lat_write;
  assign a_addr  = state == IDLE ? req_addr[AW+2:0] : lat_addr;
  assign a_size  = state == IDLE ? size_t'(req_size) : lat_size;
  assign a_wdata = state == IDLE ? req_wdata : lat_wdata;
  assign lane    = a_addr[2:0];
  assign accept  = state == IDLE && req_valid && req_ready;
  assign done    = (state == WAIT && cnt == '0) || (accept && WAIT_CYCLES == 0);
  assign mis     = |(lane & 3'((4'd1 << a_size) - 4'd1));
  assign we      = done && a_write && !mis ? byte_mask(a_size, lane) : 8'h00;
  assign sz_mask = a_size == SZ_D ? '1 : (64'd1 << (7'd8 << a_size)) - 64'd1;
  assign ld_data = a_write || mis ? '0 : (ram_rd >> {lane, 3'b000}) & sz_mask;
  dm_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk  (clk),
    .idx  (a_addr[AW+2:3]),
    .we   (we),
    .wdata(a_wdata << {lane, 3'b000}),
    .rdata(ram_rd)
  );
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_size   <= SZ_B;
      lat_wdata  <= '0;
    end else
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            lat_write <= req_write;
            lat_addr  <= req_addr[AW+2:0];
            lat_size  <= size_t'(req_size);
            lat_wdata <= req_wdata;
            cnt       <= CW'(WAIT_CYCLES - 1);
            if (done) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= ld_data;
              resp_err   <= mis;
            end else state <= WAIT;
          end
        end
        WAIT:
          if (done) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= ld_data;
            resp_err   <= mis;
          end else cnt <= cnt - 1'b1;
        RESP:
          if (resp_ready) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            req_ready  <= 1'b1;
          end
        default: state <= IDLE;
      endcase
endmodule
